// File: rtl/ahblite_bram_ctrl.sv
// AHB-Lite slave in front of a synchronous 1-cycle BRAM: zero-wait writes, optional read
// wait states, two-cycle ERROR responses and write-to-read forwarding for same-word hazards.
module ahblite_bram_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int MEM_WORDS  = 2**ADDR_WIDTH,
  parameter int RD_WAIT    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic [1:0]            HRESP,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  input  logic [31:0]           BRAM_RDATA,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE
);
  typedef enum logic [1:0] {S_IDLE, S_RWAIT, S_ERR1, S_ERR2} state_t;

  state_t                state;
  logic                  rdy_q, err_q;
  logic [1:0]            wait_cnt;
  logic                  wr_pend, hazard;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [3:0]            wr_strb, fwd_strb;
  logic [31:0]           fwd_data;

  logic [ADDR_WIDTH-1:0] widx;
  logic [3:0]            strb;
  logic                  open, accept, illegal, rd_ok, wr_ok, hit;
  logic                  unused_bits;

  assign widx        = HADDR[ADDR_WIDTH+1:2];
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  // An address phase can only be taken while the slave itself is ready.
  assign open   = (state == S_IDLE) || (state == S_ERR2);
  assign accept = open && HSEL && HTRANS[1] && HREADY;
  assign rd_ok  = accept && !illegal && !HWRITE;
  assign wr_ok  = accept && !illegal && HWRITE;
  assign hit    = rd_ok && wr_pend && (widx == wr_addr);

  always_comb begin
    strb    = 4'h0;
    illegal = 1'b0;
    case (HSIZE)
      3'd0: strb = 4'b0001 << HADDR[1:0];
      3'd1: begin
        strb    = HADDR[1] ? 4'hC : 4'h3;
        illegal = HADDR[0];
      end
      3'd2: begin
        strb    = 4'hF;
        illegal = (HADDR[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    if (32'(widx) >= 32'(MEM_WORDS)) illegal = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= 2'd0;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR2: begin
          if (accept && illegal) begin
            state <= S_ERR1;
            rdy_q <= 1'b0;
            err_q <= 1'b1;
          end else if (rd_ok && RD_WAIT > 0) begin
            state    <= S_RWAIT;
            wait_cnt <= 2'(RD_WAIT);
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
          end else begin
            state <= S_IDLE;
            rdy_q <= 1'b1;
            err_q <= 1'b0;
          end
        end
        S_ERR1: begin
          state <= S_ERR2;
          rdy_q <= 1'b1;
          err_q <= 1'b1;
        end
        S_RWAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt == 2'd1) begin
            state <= S_IDLE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          rdy_q <= 1'b1;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_strb  <= 4'h0;
      rd_addr  <= '0;
      hazard   <= 1'b0;
      fwd_data <= 32'h0;
      fwd_strb <= 4'h0;
    end else begin
      wr_pend <= wr_ok;
      if (wr_ok) begin
        wr_addr <= widx;
        wr_strb <= strb;
      end
      if (rd_ok) rd_addr <= widx;
      // Hazard state is held through RWAIT and refreshed at every open cycle.
      if (open) begin
        hazard <= hit;
        if (hit) begin
          fwd_data <= HWDATA;
          fwd_strb <= wr_strb;
        end
      end
    end
  end

  assign HREADYOUT   = rdy_q;
  assign HRESP       = {1'b0, err_q};
  assign BRAM_RDADDR = (state == S_RWAIT) ? rd_addr : widx;
  assign BRAM_WRADDR = wr_addr;
  assign BRAM_WDATA  = HWDATA;
  assign BRAM_WRITE  = wr_pend ? wr_strb : 4'h0;

  always_comb begin
    HRDATA = BRAM_RDATA;
    for (int b = 0; b < 4; b++)
      if (hazard && fwd_strb[b]) HRDATA[8*b +: 8] = fwd_data[8*b +: 8];
  end
endmodule

// File: tb/tb_ahblite_bram_ctrl.sv
// Bench for ahblite_bram_ctrl: a zero-wait instance (MEM_WORDS=1000) and an RD_WAIT=2 instance,
// each with its own BRAM model, driven by a pipelined AHB master from vector tables.
module tb_ahblite_bram_ctrl;
  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [3:0]  cyc;
  } vec_t;

  logic        hclk = 1'b0, hresetn = 1'b0, hsel = 1'b0, sel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = 32'h0, hwdata = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0;
  logic        hsel_a, hsel_b, rdy_a, rdy_b;
  logic [31:0] rdata_a, rdata_b, brd_a, brd_b, bwd_a, bwd_b;
  logic [1:0]  resp_a, resp_b;
  logic [10:0] rda_a, rda_b, wra_a, wra_b;
  logic [3:0]  bw_a, bw_b;
  logic [31:0] mem_a [2048];
  logic [31:0] mem_b [2048];

  logic        rdy, bwr_unused;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic [10:0] rda, wra;
  logic [3:0]  bwr;

  int   n_chk = 0, n_fail = 0;
  vec_t vq[$];
  vec_t exp_q[$];

  always #5 hclk = ~hclk;

  assign hsel_a = hsel & ~sel;
  assign hsel_b = hsel & sel;
  assign rdy    = sel ? rdy_b : rdy_a;
  assign rdata  = sel ? rdata_b : rdata_a;
  assign resp   = sel ? resp_b : resp_a;
  assign rda    = sel ? rda_b : rda_a;
  assign wra    = sel ? wra_b : wra_a;
  assign bwr    = sel ? bw_b : bw_a;
  assign bwr_unused = 1'b0;

  ahblite_bram_ctrl #(.ADDR_WIDTH(11), .MEM_WORDS(1000), .RD_WAIT(0)) u_a (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy_a), .HREADYOUT(rdy_a),
    .HRDATA(rdata_a), .HRESP(resp_a), .BRAM_RDADDR(rda_a), .BRAM_WRADDR(wra_a),
    .BRAM_RDATA(brd_a), .BRAM_WDATA(bwd_a), .BRAM_WRITE(bw_a));

  ahblite_bram_ctrl #(.ADDR_WIDTH(11), .RD_WAIT(2)) u_b (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy_b), .HREADYOUT(rdy_b),
    .HRDATA(rdata_b), .HRESP(resp_b), .BRAM_RDADDR(rda_b), .BRAM_WRADDR(wra_b),
    .BRAM_RDATA(brd_b), .BRAM_WDATA(bwd_b), .BRAM_WRITE(bw_b));

  // Read-first synchronous BRAM models with byte enables.
  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 32'h5A00_0000 | 32'(i);
      mem_b[i] = 32'h5A00_0000 | 32'(i);
    end
    mem_a[8] = 32'h1111_1111;
    mem_b[8] = 32'h1111_1111;
    forever begin
      @(posedge hclk);
      brd_a <= mem_a[rda_a];
      brd_b <= mem_b[rda_b];
      for (int b = 0; b < 4; b++) begin
        if (bw_a[b]) mem_a[wra_a][8*b +: 8] = bwd_a[8*b +: 8];
        if (bw_b[b]) mem_b[wra_b][8*b +: 8] = bwd_b[8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err, input logic [3:0] strb,
                              input logic [31:0] rdat, input logic [3:0] cyc);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.err = err; v.strb = strb; v.rdata = rdat; v.cyc = cyc;
    return v;
  endfunction

  task automatic add(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic err, input logic [3:0] strb,
                     input logic [31:0] rdat, input logic [3:0] cyc);
    vq.push_back(mk(wr, size, addr, wdata, err, strb, rdat, cyc));
  endtask

  task automatic drive(input vec_t v);
    hsel = 1'b1; htrans = 2'b10; hwrite = v.wr; hsize = v.size; haddr = v.addr;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_hreadyout_a"}, 32'(rdy_a), 32'd1);
    chk({nm, "_hresp_a"}, 32'(resp_a), 32'd0);
    chk({nm, "_bram_write_a"}, 32'(bw_a), 32'd0);
    chk({nm, "_hreadyout_b"}, 32'(rdy_b), 32'd1);
    chk({nm, "_hresp_b"}, 32'(resp_b), 32'd0);
    chk({nm, "_bram_write_b"}, 32'(bw_b), 32'd0);
  endtask

  // Pipelined master: expected records enter the scoreboard when their address phase is
  // accepted and are checked cycle by cycle until their data phase completes.
  task automatic run_vecs();
    vec_t cur;
    int   idx = 0, guard = 0, dp_cyc = 0;
    logic a_vld = 1'b0, rdy_s = 1'b0;
    logic [3:0] ew;
    @(posedge hclk); #1;
    if (vq.size() > 0) begin cur = vq[0]; idx = 1; drive(cur); a_vld = 1'b1; end
    while (a_vld || exp_q.size() > 0) begin
      @(negedge hclk);
      rdy_s = rdy;
      if (exp_q.size() > 0) begin
        vec_t d = exp_q[0];
        dp_cyc++;
        ew = (d.wr && !d.err && dp_cyc == 1) ? d.strb : 4'h0;
        chk("bram_write", 32'(bwr), 32'(ew));
        if (ew != 4'h0) chk("bram_wraddr", 32'(wra), 32'(d.addr[12:2]));
        chk("hresp", 32'(resp), 32'(d.err));
        if (!rdy && !d.wr && !d.err) chk("bram_rdaddr_hold", 32'(rda), 32'(d.addr[12:2]));
        if (rdy) begin
          chk("dphase_cycles", 32'(dp_cyc), 32'(d.cyc));
          if (!d.wr && !d.err) chk("hrdata", rdata, d.rdata);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("bram_write_idle", 32'(bwr), 32'd0);
      end
      @(posedge hclk); #1;
      if (rdy_s) begin
        if (a_vld) begin exp_q.push_back(cur); hwdata = cur.wdata; dp_cyc = 0; end
        if (idx < vq.size()) begin cur = vq[idx]; idx++; drive(cur); a_vld = 1'b1; end
        else begin a_vld = 1'b0; idle_bus(); end
      end
      guard++;
      if (guard > 400) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: %0d cycles without finishing, limit 400", guard);
        exp_q.delete();
        idle_bus();
        break;
      end
    end
    vq.delete();
  endtask

  initial begin
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk_rst("reset");
    @(posedge hclk); #1 hresetn = 1'b1;

    // Zero-wait instance: forwarding, byte/half lanes, errors, address wrap, bounds.
    sel = 1'b0;
    add(1, 2, 32'h10,   32'hA5A5_1234, 0, 4'hF, 32'h0,         1);
    add(0, 2, 32'h10,   32'h0,         0, 4'h0, 32'hA5A5_1234, 1);
    add(1, 0, 32'h21,   32'h0000_7700, 0, 4'h2, 32'h0,         1);
    add(0, 2, 32'h20,   32'h0,         0, 4'h0, 32'h1111_7711, 1);
    add(0, 2, 32'h10,   32'h0,         0, 4'h0, 32'hA5A5_1234, 1);
    add(0, 2, 32'h02,   32'h0,         1, 4'h0, 32'h0,         2);
    add(1, 1, 32'h03,   32'hFFFF_FFFF, 1, 4'h0, 32'h0,         2);
    add(0, 2, 32'hFA0,  32'h0,         1, 4'h0, 32'h0,         2);
    add(1, 2, 32'hF9C,  32'hDEAD_BEEF, 0, 4'hF, 32'h0,         1);
    add(0, 2, 32'hF9C,  32'h0,         0, 4'h0, 32'hDEAD_BEEF, 1);
    add(1, 1, 32'h46,   32'hBEEF_0000, 0, 4'hC, 32'h0,         1);
    add(0, 0, 32'h45,   32'h0,         0, 4'h0, 32'hBEEF_0011, 1);
    add(1, 2, 32'h30,   32'h1234_5678, 0, 4'hF, 32'h0,         1);
    add(0, 3, 32'h30,   32'h0,         1, 4'h0, 32'h0,         2);
    add(0, 2, 32'h30,   32'h0,         0, 4'h0, 32'h1234_5678, 1);
    add(0, 2, 32'h8010, 32'h0,         0, 4'h0, 32'hA5A5_1234, 1);
    add(1, 0, 32'h13,   32'hCC00_0000, 0, 4'h8, 32'h0,         1);
    add(1, 0, 32'h12,   32'h00BB_0000, 0, 4'h4, 32'h0,         1);
    add(0, 2, 32'h10,   32'h0,         0, 4'h0, 32'hCCBB_1234, 1);
    add(1, 2, 32'h0E,   32'h0000_0000, 1, 4'h0, 32'h0,         2);
    run_vecs();

    // Two-wait-state instance.
    sel = 1'b1;
    add(0, 2, 32'h40, 32'h0,         0, 4'h0, 32'h5A00_0010, 3);
    add(1, 2, 32'h40, 32'h0102_0304, 0, 4'hF, 32'h0,         1);
    add(0, 2, 32'h40, 32'h0,         0, 4'h0, 32'h0102_0304, 3);
    add(0, 2, 32'h44, 32'h0,         0, 4'h0, 32'h5A00_0011, 3);
    add(0, 1, 32'h41, 32'h0,         1, 4'h0, 32'h0,         2);
    run_vecs();

    // Reset in the middle of RWAIT.
    @(posedge hclk); #1 drive(mk(0, 2, 32'h40, 0, 0, 0, 0, 3));
    @(posedge hclk); #1 idle_bus();
    @(negedge hclk);
    chk("rwait_hreadyout", 32'(rdy_b), 32'd0);
    #1 hresetn = 1'b0;
    #1 chk_rst("rst_rwait");
    @(posedge hclk); #1 hresetn = 1'b1;

    // Reset during a write data phase: the write must never reach the BRAM.
    sel = 1'b0;
    @(posedge hclk); #1 drive(mk(1, 2, 32'h60, 0, 0, 0, 0, 1));
    @(posedge hclk); #1 idle_bus(); hwdata = 32'hFFFF_0000;
    @(negedge hclk);
    chk("wr_dphase_bram_write", 32'(bw_a), 32'hF);
    #1 hresetn = 1'b0;
    #1 chk_rst("rst_wr");
    @(posedge hclk); #1 hresetn = 1'b1;
    @(posedge hclk); #1 chk("no_write_after_rst", mem_a[24], 32'h5A00_0018);

    // Reset during ERR1.
    @(posedge hclk); #1 drive(mk(0, 2, 32'h02, 0, 1, 0, 0, 2));
    @(posedge hclk); #1 idle_bus();
    @(negedge hclk);
    chk("err1_hresp", 32'(resp_a), 32'd1);
    chk("err1_hreadyout", 32'(rdy_a), 32'd0);
    #1 hresetn = 1'b0;
    #1 chk_rst("rst_err1");
    @(posedge hclk); #1 hresetn = 1'b1;

    // First transfers after reset release behave normally.
    add(0, 2, 32'h10, 32'h0, 0, 4'h0, 32'hCCBB_1234, 1);
    run_vecs();
    sel = 1'b1;
    add(0, 2, 32'h40, 32'h0, 0, 4'h0, 32'h0102_0304, 3);
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahblite_bram_ctrl.md
AHBLITE_BRAM_CTRL -- requirements
Module: ahblite_bram_ctrl

Interface
REQ-001 Parameters: ADDR_WIDTH, default 11, BRAM word-address width. MEM_WORDS, default 2**ADDR_WIDTH, populated words. RD_WAIT, default 0, read wait states, legal range 0..3.
REQ-002 HCLK  in  1  sole clock; all state updates on rising edge.
REQ-003 HRESETn  in  1  asynchronous, active-low reset.
REQ-004 HSEL  in  1  slave select.
REQ-005 HADDR  in  32  byte address.
REQ-006 HTRANS  in  2  transfer type.
REQ-007 HSIZE  in  3  transfer size.
REQ-008 HWRITE  in  1  1 = write.
REQ-009 HWDATA  in  32  write data, valid in data phase.
REQ-010 HREADY  in  1  bus ready; an address phase is accepted only when it is 1.
REQ-011 HREADYOUT  out  1  slave ready.
REQ-012 HRDATA  out  32  read data.
REQ-013 HRESP  out  2  bit0 = ERROR; bit1 is tied to 0.
REQ-014 BRAM_RDADDR  out  ADDR_WIDTH  BRAM read word address; synchronous BRAM with 1-cycle read latency.
REQ-015 BRAM_WRADDR  out  ADDR_WIDTH  BRAM write word address.
REQ-016 BRAM_RDATA  in  32  BRAM read data.
REQ-017 BRAM_WDATA  out  32  BRAM write data; equals HWDATA.
REQ-018 BRAM_WRITE  out  4  per-byte write enables.

Function
REQ-019 Accepted transfer: HSEL & HTRANS[1] & HREADY. IDLE and BUSY transfers get a zero-wait OKAY response and cause no BRAM write.
REQ-020 Byte strobe decode, by HADDR[1:0] and HSIZE:
  - byte: 1<<HADDR[1:0].
  - half: 4'h3 at offset 0, 4'hC at offset 2.
  - word: 4'hF at offset 0.
REQ-021 Illegal access is any of:
  - HSIZE > 2;
  - half-word with HADDR[0]=1;
  - word with HADDR[1:0] != 0;
  - word index HADDR[ADDR_WIDTH+1:2] >= MEM_WORDS;
  - HADDR above bit ADDR_WIDTH+1 is ignored.
REQ-022 FSM states: IDLE, RWAIT, ERR1, ERR2. Reset state is IDLE.
REQ-023 IDLE transitions:
  - accepted illegal access -> ERR1;
  - accepted read with RD_WAIT>0 -> RWAIT, with wait counter loaded to RD_WAIT;
  - otherwise stay in IDLE.
REQ-024 ERR1: HREADYOUT=0, HRESP=1; next state ERR2. ERR2: HREADYOUT=1, HRESP=1; next state follows the IDLE rules for the current address phase.
REQ-025 RWAIT: HREADYOUT=0; counter decrements each cycle. On reaching 1, the next cycle outputs HREADYOUT=1, and the FSM applies the IDLE rules to the current address phase.
REQ-026 Read latency: RD_WAIT+1 cycles from address phase to data-phase completion. RD_WAIT=0 gives zero-wait reads.
REQ-027 BRAM_RDADDR source:
  - equals HADDR[ADDR_WIDTH+1:2] combinationally in IDLE/ERR2;
  - equals the latched read address in RWAIT.
REQ-028 Writes are always zero-wait. Address and strobe are latched at the accepted address phase. In the following cycle:
  - BRAM_WRITE = latched strobe;
  - BRAM_WRADDR = latched address.
  At all other times BRAM_WRITE = 0.
REQ-029 Illegal writes never assert BRAM_WRITE.
REQ-030 Forwarding: a read address phase that coincides with a write data phase to the same word sets a hazard flag. HWDATA and the strobe are captured in that cycle.
REQ-031 In the hazard read's completing data phase, HRDATA per byte lane = the captured write byte where the strobe bit is 1, else BRAM_RDATA.
REQ-032 Without a hazard, HRDATA = BRAM_RDATA.
REQ-033 Back-to-back transfers in any read/write mix are pipelined without bubbles, except where RWAIT or ERR states apply.
REQ-034 HRESP=0 in all states except ERR1 and ERR2.

Reset
REQ-035 HRESETn low forces, immediately and regardless of the current state:
  - FSM to IDLE;
  - wait counter, hazard flag, latched strobe, address and capture registers to 0;
  - HREADYOUT=1, HRESP=0, BRAM_WRITE=0.
REQ-036 Reset during RWAIT, ERR1 or a write data phase abandons the transfer. No BRAM write occurs after reset asserts.
REQ-037 After reset release, the first accepted address phase is processed normally.

Verification
REQ-038 RD_WAIT=0: word write 0xA5A5_1234 @0x10, then read @0x10 -> BRAM_WRITE=4'hF with BRAM_WRADDR=4 in cycle 2. The read data phase returns 0xA5A5_1234 via forwarding, HREADYOUT=1 throughout.
REQ-039 Byte write 0xXXXX_77XX @0x21, then word read @0x20 with BRAM holding 0x1111_1111 -> BRAM_WRITE=4'h2; HRDATA=0x1111_7711.
REQ-040 RD_WAIT=2: read @0x40 -> HREADYOUT low for exactly 2 cycles, BRAM_RDADDR held at 16, data returned on the 3rd cycle.
REQ-041 Word read @0x02, and separately half-word write @0x03 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). BRAM_WRITE stays 0.
REQ-042 MEM_WORDS=1000: access @0xFA0 -> two-cycle ERROR. Assert HRESETn low mid-RWAIT -> outputs return to reset values in the same cycle.
